// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks EX/MEM/WB destinations to produce operand forwarding
// selects, load-use stalls, redirect bubbles and stall/flush event counters.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [ADDR_W-1:0] dest;
  } stage_t;

  typedef struct packed {
    stage_t            base;
    logic              use_rs;
    logic              use_rt;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } ex_stage_t;

  localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_stage_t        e_q, e_d;
  stage_t           m_q, m_d, w_q, w_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             stall_s;
  logic             bubble_s;

  // M is the younger producer and wins over W; loads in M have no data yet.
  function automatic logic [1:0] fwd_sel(
    input logic              e_valid,
    input logic              use_src,
    input logic [ADDR_W-1:0] src,
    input stage_t            m,
    input stage_t            w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_valid && use_src && (src != ZERO_REG)) begin
      if (m.valid && m.regwrite && !m.memread && (m.dest == src)) begin
        sel = 2'b01;
      end else if (w.valid && w.regwrite && (w.dest == src)) begin
        sel = 2'b10;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use detection against the load sitting in EX; a redirect squashes the consumer.
  always_comb begin
    logic load_in_ex;
    logic src_hit;
    load_in_ex = e_q.base.valid && e_q.base.memread && (e_q.base.dest != ZERO_REG);
    src_hit    = (id_use_rs && (id_rs == e_q.base.dest)) ||
                 (id_use_rt && (id_rt == e_q.base.dest));
    stall_s    = id_valid && load_in_ex && src_hit && !ex_redirect;
    bubble_s   = stall_s || ex_redirect;
  end

  // Next-state: pipeline shift, bubble insertion and event counting.
  always_comb begin
    m_d           = e_q.base;
    w_d           = m_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    e_d           = '0;
    if (bubble_s) begin
      e_d = '0;
    end else begin
      e_d.base.valid    = id_valid;
      e_d.base.regwrite = id_regwrite;
      e_d.base.memread  = id_memread;
      e_d.base.dest     = id_dest;
      e_d.use_rs        = id_use_rs;
      e_d.use_rt        = id_use_rt;
      e_d.rs            = id_rs;
      e_d.rt            = id_rt;
    end
    if (stall_s) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (ex_redirect) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q           <= '0;
      m_q           <= '0;
      w_q           <= '0;
      stall_count_q <= {CNT_W{1'b0}};
      flush_count_q <= {CNT_W{1'b0}};
    end else begin
      e_q           <= e_d;
      m_q           <= m_d;
      w_q           <= w_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall       = stall_s;
  assign bubble_idex = bubble_s;
  assign flush_ifid  = ex_redirect;
  assign fwd_a       = fwd_sel(e_q.base.valid, e_q.use_rs, e_q.rs, m_q, w_q);
  assign fwd_b       = fwd_sel(e_q.base.valid, e_q.use_rt, e_q.rt, m_q, w_q);
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instruction sequences with hand-derived
// forwarding, stall, bubble, flush and counter expectations.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic        ex_redirect;
  logic        stall, bubble_idex, flush_ifid;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count, flush_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  hazard_scoreboard #(.ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect),
    .stall(stall), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dest, input logic rw,
                        input logic mr);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = dest; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_dest = 5'd0; id_regwrite = 1'b0; id_memread = 1'b0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_redirect = 1'b0;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else pass_cnt++;
      chk_cnt++; if (fwd_a !== 2'b00) $display("FAIL reset_fwd_a: got %b want 00", fwd_a); else pass_cnt++;
      chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL reset_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
      chk_cnt++; if (stall_count !== 32'd0) $display("FAIL reset_stall_count: got %0d want 0", stall_count); else pass_cnt++;
      chk_cnt++; if (flush_count !== 32'd0) $display("FAIL reset_flush_count: got %0d want 0", flush_count); else pass_cnt++;
    end
  endtask

  // ADDI $t1,$zero,5 ; SUB $t3,$t1,$t2
  task automatic test_ex_forward();
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL exfwd_stall_id: got %0b want 0", stall); else pass_cnt++;
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b01) $display("FAIL exfwd_fwd_a: got %b want 01", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL exfwd_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
    chk_cnt++; if (stall_count !== 32'd0) $display("FAIL exfwd_stall_count: got %0d want 0", stall_count); else pass_cnt++;
    drain();
  endtask

  // ADDI $t1 ; ADDI $t3,$zero,1 ; XORI $t4,$t1,3
  task automatic test_wb_forward();
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd11, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    tick();
    set_id(5'd9, 5'd12, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b10) $display("FAIL wbfwd_fwd_a: got %b want 10", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL wbfwd_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
    drain();
  endtask

  // ADDI $t1 ; ADDI $t1 ; ADD $t3,$t1,$t1 -> younger producer in M wins on both operands
  task automatic test_priority();
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b01) $display("FAIL prio_fwd_a: got %b want 01", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b01) $display("FAIL prio_fwd_b: got %b want 01", fwd_b); else pass_cnt++;
    drain();
  endtask

  // LW $t2,0($zero) ; SLT $t5,$t2,$t1
  task automatic test_load_use();
    set_id(5'd0, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    set_id(5'd10, 5'd9, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    chk_cnt++; if (stall !== 1'b1) $display("FAIL lu_stall: got %0b want 1", stall); else pass_cnt++;
    chk_cnt++; if (bubble_idex !== 1'b1) $display("FAIL lu_bubble: got %0b want 1", bubble_idex); else pass_cnt++;
    tick();
    chk_cnt++; if (stall !== 1'b0) $display("FAIL lu_stall_once: got %0b want 0", stall); else pass_cnt++;
    chk_cnt++; if (bubble_idex !== 1'b0) $display("FAIL lu_bubble_once: got %0b want 0", bubble_idex); else pass_cnt++;
    chk_cnt++; if (stall_count !== 32'd1) $display("FAIL lu_stall_count: got %0d want 1", stall_count); else pass_cnt++;
    chk_cnt++; if (fwd_a !== 2'b00) $display("FAIL lu_bubble_fwd_a: got %b want 00", fwd_a); else pass_cnt++;
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a: got %b want 10", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL lu_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
    chk_cnt++; if (stall_count !== 32'd1) $display("FAIL lu_stall_count_hold: got %0d want 1", stall_count); else pass_cnt++;
    drain();
  endtask

  // LW $t2 in EX, consumer in ID, redirect in the same cycle
  task automatic test_redirect();
    set_id(5'd0, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    set_id(5'd10, 5'd9, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    chk_cnt++; if (stall !== 1'b0) $display("FAIL redir_stall: got %0b want 0", stall); else pass_cnt++;
    chk_cnt++; if (bubble_idex !== 1'b1) $display("FAIL redir_bubble: got %0b want 1", bubble_idex); else pass_cnt++;
    chk_cnt++; if (flush_ifid !== 1'b1) $display("FAIL redir_flush_ifid: got %0b want 1", flush_ifid); else pass_cnt++;
    tick();
    ex_redirect = 1'b0;
    idle();
    chk_cnt++; if (flush_count !== 32'd1) $display("FAIL redir_flush_count: got %0d want 1", flush_count); else pass_cnt++;
    chk_cnt++; if (stall_count !== 32'd1) $display("FAIL redir_stall_count: got %0d want 1", stall_count); else pass_cnt++;
    chk_cnt++; if (flush_ifid !== 1'b0) $display("FAIL redir_flush_clear: got %0b want 0", flush_ifid); else pass_cnt++;
    chk_cnt++; if (fwd_a !== 2'b00) $display("FAIL redir_squash_fwd_a: got %b want 00", fwd_a); else pass_cnt++;
    drain();
  endtask

  // ADDI $zero,$zero,7 ; ADD $t6,$zero,$zero ; then LW $zero with a $zero reader
  task automatic test_zero_reg();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b00) $display("FAIL zero_fwd_a: got %b want 00", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL zero_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
    drain();
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    chk_cnt++; if (stall !== 1'b0) $display("FAIL zero_load_stall: got %0b want 0", stall); else pass_cnt++;
    drain();
  endtask

  // Reset while ADDI $t1 is in MEM; reset also overrides a live ID word and redirect
  task automatic test_reset_mid();
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    ex_redirect = 1'b1;
    set_id(5'd0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    ex_redirect = 1'b0;
    set_id(5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    chk_cnt++; if (stall_count !== 32'd0) $display("FAIL rmid_stall_count: got %0d want 0", stall_count); else pass_cnt++;
    chk_cnt++; if (flush_count !== 32'd0) $display("FAIL rmid_flush_count: got %0d want 0", flush_count); else pass_cnt++;
    tick();
    idle();
    chk_cnt++; if (fwd_a !== 2'b00) $display("FAIL rmid_fwd_a: got %b want 00", fwd_a); else pass_cnt++;
    chk_cnt++; if (fwd_b !== 2'b00) $display("FAIL rmid_fwd_b: got %b want 00", fwd_b); else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_priority();
    test_load_use();
    test_redirect();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
